// File: rtl/taxi_pkg.sv
// Shared definitions for the taxi meter controller: state encoding,
// datapath widths and the saturating km adder used by the mile counter.
package taxi_pkg;

    localparam int MILE_W = 13;
    localparam int FARE_W = 13;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;
    localparam logic [1:0] ST_SHOW = 2'd3;

    // Adds 0..2 km to the running count, pinning at the all-ones ceiling.
    function automatic logic [MILE_W-1:0] mile_sat_add(input logic [MILE_W-1:0] base,
                                                       input logic [1:0]        inc);
        logic [MILE_W:0] sum;
        sum = {1'b0, base} + {{(MILE_W-1){1'b0}}, inc};
        return sum[MILE_W] ? {MILE_W{1'b1}} : sum[MILE_W-1:0];
    endfunction

endpackage

// File: rtl/mile_counter.sv
// Wheel-pulse divider and saturating km counter. 'extra' adds one km in the
// same cycle as a wheel-derived km (used for waiting-time charge).
module mile_counter
    import taxi_pkg::*;
#(
    parameter int PPK = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clr,
    input  logic              en,
    input  logic              pulse,
    input  logic              extra,
    output logic [MILE_W-1:0] mile
);

    localparam int PC_W = (PPK > 1) ? $clog2(PPK) : 1;

    logic [PC_W-1:0] pulse_cnt;
    logic            wrap;
    logic [1:0]      km_inc;

    assign wrap   = pulse && (pulse_cnt == PC_W'(PPK - 1));
    assign km_inc = {1'b0, wrap} + {1'b0, extra};

    // Divide wheel pulses down to km; a partial km is simply dropped on clear.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            pulse_cnt <= '0;
            mile      <= '0;
        end else if (en) begin
            if (pulse)
                pulse_cnt <= wrap ? '0 : pulse_cnt + 1'b1;
            mile <= mile_sat_add(mile, km_inc);
        end
    end

endmodule

// File: rtl/taxi_ctrl.sv
// Taxi meter trip sequencer. Optional waiting-time charge is built only when
// TAXI_WAIT_CHARGE_EN is defined; the default build has no wait counter.
//
// state | meaning
// IDLE  | no trip; fare datapath held clear, mile held at 0
// RUN   | trip in progress; wheel pulses accumulate km
// CALC  | one cycle for the fare datapath register to catch up
// SHOW  | settled fare displayed for SHOW_SEC seconds
module taxi_ctrl
    import taxi_pkg::*;
#(
    parameter int PPK      = 10,
    parameter int SHOW_SEC = 5,
    parameter int WAIT_SEC = 60
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              stop,
    input  logic              wheel_pulse,
    input  logic              sec_tick,
    input  logic [FARE_W-1:0] fare_in,
    output logic [MILE_W-1:0] mile,
    output logic              fare_rst,
    output logic [FARE_W-1:0] fare_hold,
    output logic              done,
    output logic [1:0]        state
);

    localparam int SEC_W = $clog2(SHOW_SEC + 1);

    logic [1:0]       state_nxt;
    logic [SEC_W-1:0] sec_cnt;
    logic             in_run;
    logic             restart;
    logic             show_to;
    logic             mile_clr;
    logic             wait_km;

    assign in_run   = (state == ST_RUN);
    assign restart  = (state == ST_SHOW) && start;
    assign show_to  = (state == ST_SHOW) && sec_tick && (sec_cnt == SEC_W'(1));
    assign fare_rst = (state == ST_IDLE) || restart;
    // Leaving SHOW for IDLE also clears mile so IDLE always shows 0.
    assign mile_clr = fare_rst || show_to;

    // Next-state decode; stop beats start in RUN, start beats timeout in SHOW.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (stop)  state_nxt = ST_CALC;
            ST_CALC: state_nxt = ST_SHOW;
            ST_SHOW: begin
                if (start)        state_nxt = ST_RUN;
                else if (show_to) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Display timer: loaded in CALC, counts seconds down while in SHOW.
    always_ff @(posedge CLK) begin
        if (RST)
            sec_cnt <= '0;
        else if (state == ST_CALC)
            sec_cnt <= SEC_W'(SHOW_SEC);
        else if ((state == ST_SHOW) && sec_tick && (sec_cnt != '0))
            sec_cnt <= sec_cnt - 1'b1;
    end

    // Latch the fare as CALC ends; clear it whenever SHOW is left.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fare_hold <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == ST_CALC);
            if (state == ST_CALC)
                fare_hold <= fare_in;
            else if (restart || show_to)
                fare_hold <= '0;
        end
    end

`ifdef TAXI_WAIT_CHARGE_EN
    localparam int WAIT_W = (WAIT_SEC > 1) ? $clog2(WAIT_SEC) : 1;

    logic [WAIT_W-1:0] wait_cnt;

    // A tick that completes WAIT_SEC still charges even if a pulse lands with it.
    assign wait_km = in_run && sec_tick && (wait_cnt == WAIT_W'(WAIT_SEC - 1));

    // Stopped-time counter: any wheel pulse restarts the wait.
    always_ff @(posedge CLK) begin
        if (RST || !in_run)
            wait_cnt <= '0;
        else if (wheel_pulse || wait_km)
            wait_cnt <= '0;
        else if (sec_tick)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    // WAIT_SEC stays referenced so both builds share one parameter list.
    assign wait_km = 1'b0 & 1'(WAIT_SEC < 0);
`endif

    mile_counter #(
        .PPK (PPK)
    ) u_mile_counter (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (mile_clr),
        .en    (in_run),
        .pulse (wheel_pulse),
        .extra (wait_km),
        .mile  (mile)
    );

endmodule

// File: doc/taxi_ctrl.md
TAXI_CTRL -- requirements
Module: taxi_ctrl

Interface
REQ-001 SHALL have parameter PPK, default 10, wheel pulses per km.
REQ-002 SHALL have parameter SHOW_SEC, default 5, seconds the settled fare is displayed.
REQ-003 SHALL have parameter WAIT_SEC, default 60, stopped seconds charged as one km (used only under WAIT_CHARGE_EN).
REQ-004 SHALL have port CLK  in  1  single system clock; all logic rising-edge.
REQ-005 SHALL have port RST  in  1  reset; synchronous and active-high.
REQ-006 SHALL have port start  in  1  passenger-board button, level, sampled each cycle.
REQ-007 SHALL have port stop  in  1  passenger-alight button, level, sampled each cycle.
REQ-008 SHALL have port wheel_pulse  in  1  one-cycle strobe per wheel sensor pulse.
REQ-009 SHALL have port sec_tick  in  1  one-cycle strobe once per second.
REQ-010 SHALL have port fare_in  in  13  registered fare from the fare datapath.
REQ-011 SHALL have port mile  out  13  km count driven to the fare datapath.
REQ-012 SHALL have port fare_rst  out  1  clear for the fare datapath.
REQ-013 SHALL have port fare_hold  out  13  latched trip fare.
REQ-014 SHALL have port done  out  1  one-cycle strobe when fare_hold is loaded.
REQ-015 SHALL have port state  out  2  current FSM state code.

Function
REQ-016 SHALL implement FSM states IDLE=0, RUN=1, CALC=2, SHOW=3.
REQ-017 IDLE: start -> RUN; stop ignored; fare_rst=1; mile held at 0.
REQ-018 On the IDLE->RUN or SHOW->RUN transition cycle, mile and pulse counter SHALL clear and fare_rst SHALL be 1 for exactly that cycle.
REQ-019 RUN: each wheel_pulse increments the pulse counter; the pulse that takes it from PPK-1 wraps it to 0 and increments mile in the same cycle.
REQ-020 mile SHALL saturate at 8191; further pulses leave mile at 8191.
REQ-021 RUN: stop -> CALC; if start and stop are both high, stop wins.
REQ-022 CALC: lasts exactly one cycle (covers the fare datapath's one-cycle register latency); mile frozen; -> SHOW.
REQ-023 On the CALC->SHOW edge, fare_hold SHALL load fare_in and done SHALL pulse high for that one cycle.
REQ-024 SHOW: mile and fare_hold frozen; count sec_tick; after SHOW_SEC ticks -> IDLE and fare_hold clears to 0.
REQ-025 SHOW: start -> RUN immediately (new trip), fare_hold cleared; start takes priority over SHOW timeout in the same cycle.
REQ-026 wheel_pulse and sec_tick outside RUN/SHOW respectively SHALL have no effect.
REQ-027 Partial pulse count SHALL be discarded at trip end (no rounding up).

Reset
REQ-028 RST SHALL force state=IDLE, mile=0, pulse/second/wait counters=0, fare_hold=0, done=0, fare_rst=1 on the next edge.
REQ-029 RST mid-trip SHALL abandon the trip without loading fare_hold or pulsing done.

Configuration
REQ-030 Macro TAXI_WAIT_CHARGE_EN: when defined, in RUN a wait counter counts sec_tick seconds with no wheel_pulse; reaching WAIT_SEC increments mile (saturating) and clears the wait counter; any wheel_pulse clears it.
REQ-031 Wait and wheel increments of mile in the same cycle SHALL both count (+2, saturating).
REQ-032 Without TAXI_WAIT_CHARGE_EN, waiting SHALL add nothing and no wait counter SHALL be synthesized.

Structure
REQ-033 Shared package taxi_pkg SHALL hold the state encoding, MILE_W=13, FARE_W=13.
REQ-034 Sub-module mile_counter SHALL contain the pulse divider and saturating mile counter (inputs clr, en, pulse, extra).

Verification
REQ-035 RST, start, 25 wheel_pulse (PPK=10) -> mile=2; stop -> CALC one cycle, done pulse, fare_hold=fare_in (13 from datapath).
REQ-036 In SHOW, 5 sec_tick -> IDLE on the 5th tick edge, fare_hold=0, fare_rst=1.
REQ-037 start and stop high together in RUN -> CALC; in SHOW start and 5th tick together -> RUN, mile=0.
REQ-038 Drive 81920 wheel_pulses -> mile stays 8191, no wrap.
REQ-039 With TAXI_WAIT_CHARGE_EN, WAIT_SEC=3: 3 sec_ticks without pulses -> mile+1; pulse after 2 ticks -> wait restarts, no increment.
REQ-040 RST asserted at mile=4 in RUN -> next cycle IDLE, mile=0, done never pulses.
